// File: rtl/pc_unit_if.sv
// Request/response bundle between the 6502 sequencer, the PC stage and the shared inc_dec.
interface pc_unit_if #(parameter int NBIT = 16);
  logic            pc_inc;
  logic            pc_load;
  logic [NBIT-1:0] load_addr;
  logic            br_take;
  logic [7:0]      br_off;
  logic [NBIT-1:0] idec_in;
  logic            idec_op;
  logic [NBIT-1:0] idec_out;
  logic [NBIT-1:0] pc_out;
  logic            busy;
  logic            page_cross;

  modport slave (
    input  pc_inc, pc_load, load_addr, br_take, br_off, idec_out,
    output idec_in, idec_op, pc_out, busy, page_cross
  );

  modport master (
    output pc_inc, pc_load, load_addr, br_take, br_off, idec_out,
    input  idec_in, idec_op, pc_out, busy, page_cross
  );
endinterface

// File: rtl/pc_unit.sv
// 6502 program counter stage: load, increment via shared inc_dec, and relative
// branches with a one-cycle high-byte fix-up on page crossing.
module pc_unit #(
  parameter int              NBIT     = 16,
  parameter logic [NBIT-1:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.slave    bus
);
  typedef enum logic {IDLE = 1'b0, BR_FIX = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NBIT-1:0] pc_q, pc_d;
  logic            hi_dir_q, hi_dir_d;
  logic [8:0]      sum9;

  assign sum9 = {1'b0, pc_q[7:0]} + {1'b0, bus.br_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hi_dir_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hi_dir_q <= hi_dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hi_dir_d = hi_dir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pc_load) begin
          pc_d = bus.load_addr;
        end else if (bus.br_take) begin
          pc_d[7:0] = sum9[7:0];
          // Carry disagreeing with the offset sign means the high byte must move.
          if (bus.br_off[7] ^ sum9[8]) begin
            hi_dir_d = ~bus.br_off[7];
            state_d  = BR_FIX;
          end
        end else if (bus.pc_inc) begin
          pc_d = bus.idec_out;
        end
      end
      BR_FIX: begin
        pc_d[NBIT-1:8] = hi_dir_q ? pc_q[NBIT-1:8] + 8'd1 : pc_q[NBIT-1:8] - 8'd1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The state bit is itself a flop, so both strobes are glitch-free.
  assign bus.busy       = (state_q == BR_FIX);
  assign bus.page_cross = (state_q == BR_FIX);
  assign bus.pc_out     = pc_q;
  assign bus.idec_in    = pc_q;
  assign bus.idec_op    = 1'b1;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expectations queued at drive time, checked after each edge.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        bsy;
  } exp_t;
  exp_t sb[$];

  pc_unit_if #(.NBIT(16)) bus ();

  pc_unit #(.NBIT(16), .RESET_PC(16'hFFFC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Shared incrementer model.
  assign bus.idec_out = bus.idec_op ? bus.idec_in + 16'd1 : bus.idec_in - 16'd1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".pc"},   bus.pc_out,            e.pc);
      chk({e.tag, ".idec"}, bus.idec_in,           e.pc);
      chk({e.tag, ".busy"}, {15'd0, bus.busy},       {15'd0, e.bsy});
      chk({e.tag, ".pcx"},  {15'd0, bus.page_cross}, {15'd0, e.bsy});
    end
  end

  task automatic cyc(input string tag, input logic ld, input logic [15:0] addr,
                     input logic br, input logic [7:0] off, input logic inc,
                     input logic [15:0] exp_pc, input logic exp_bsy);
    exp_t e;
    @(negedge clk);
    bus.pc_load   = ld;
    bus.load_addr = addr;
    bus.br_take   = br;
    bus.br_off    = off;
    bus.pc_inc    = inc;
    e.tag = tag; e.pc = exp_pc; e.bsy = exp_bsy;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pc_load = 0; bus.load_addr = '0; bus.br_take = 0; bus.br_off = '0; bus.pc_inc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.pc",   bus.pc_out, 16'hFFFC);
      chk("rst.busy", {15'd0, bus.busy}, 16'd0);
      chk("rst.pcx",  {15'd0, bus.page_cross}, 16'd0);
    end
    rst_n = 1'b1;
    cyc("idle",   0, 16'h0000, 0, 8'h00, 0, 16'hFFFC, 0);
    // increment wrap
    cyc("ld_fffe",0, 16'h0000, 0, 8'h00, 0, 16'hFFFC, 0);
    cyc("ld_fffe",1, 16'hFFFE, 0, 8'h00, 0, 16'hFFFE, 0);
    cyc("inc1",   0, 16'h0000, 0, 8'h00, 1, 16'hFFFF, 0);
    cyc("inc2",   0, 16'h0000, 0, 8'h00, 1, 16'h0000, 0);
    cyc("inc3",   0, 16'h0000, 0, 8'h00, 1, 16'h0001, 0);
    // forward branches
    cyc("ld_10f0",1, 16'h10F0, 0, 8'h00, 0, 16'h10F0, 0);
    cyc("fwd_nc", 0, 16'h0000, 1, 8'h08, 0, 16'h10F8, 0);
    cyc("ld_10f0",1, 16'h10F0, 0, 8'h00, 0, 16'h10F0, 0);
    cyc("fwd_x1", 0, 16'h0000, 1, 8'h20, 0, 16'h1010, 1);
    cyc("fwd_x2", 0, 16'h0000, 0, 8'h00, 0, 16'h1110, 0);
    // backward branches, including high byte 00 -> FF
    cyc("ld_2005",1, 16'h2005, 0, 8'h00, 0, 16'h2005, 0);
    cyc("bwd_x1", 0, 16'h0000, 1, 8'hF0, 0, 16'h20F5, 1);
    cyc("bwd_x2", 0, 16'h0000, 0, 8'h00, 0, 16'h1FF5, 0);
    cyc("ld_0005",1, 16'h0005, 0, 8'h00, 0, 16'h0005, 0);
    cyc("bwdw_1", 0, 16'h0000, 1, 8'hF0, 0, 16'h00F5, 1);
    cyc("bwdw_2", 0, 16'h0000, 0, 8'h00, 0, 16'hFFF5, 0);
    // priority, zero offset, -128 offset
    cyc("prio",   1, 16'h4000, 1, 8'h20, 1, 16'h4000, 0);
    cyc("br_zero",0, 16'h0000, 1, 8'h00, 0, 16'h4000, 0);
    cyc("br_80_1",0, 16'h0000, 1, 8'h80, 0, 16'h4080, 1);
    cyc("br_80_2",0, 16'h0000, 0, 8'h00, 0, 16'h3F80, 0);
    cyc("br_inc", 0, 16'h0000, 1, 8'h01, 1, 16'h3F81, 0);
    // requests masked in BR_FIX, then a held load acts on the next IDLE edge
    cyc("ld_10f0",1, 16'h10F0, 0, 8'h00, 0, 16'h10F0, 0);
    cyc("mask_1", 0, 16'h0000, 1, 8'h20, 0, 16'h1010, 1);
    cyc("mask_2", 1, 16'h9999, 1, 8'h20, 1, 16'h1110, 0);
    cyc("held_ld",1, 16'h9999, 0, 8'h00, 0, 16'h9999, 0);
    // high byte FF -> 00
    cyc("ld_fff0",1, 16'hFFF0, 0, 8'h00, 0, 16'hFFF0, 0);
    cyc("fwdw_1", 0, 16'h0000, 1, 8'h20, 0, 16'hFF10, 1);
    cyc("fwdw_2", 0, 16'h0000, 0, 8'h00, 0, 16'h0010, 0);
    // reset while in BR_FIX
    cyc("ld_2005",1, 16'h2005, 0, 8'h00, 0, 16'h2005, 0);
    cyc("rfix_1", 0, 16'h0000, 1, 8'hF0, 0, 16'h20F5, 1);
    @(negedge clk);
    bus.br_take = 0;
    rst_n = 1'b0;
    #1;
    chk("rfix.pc",   bus.pc_out, 16'hFFFC);
    chk("rfix.busy", {15'd0, bus.busy}, 16'd0);
    chk("rfix.pcx",  {15'd0, bus.page_cross}, 16'd0);
    @(posedge clk); #1;
    chk("rfix.hold", bus.pc_out, 16'hFFFC);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rfix_idle",0, 16'h0000, 0, 8'h00, 0, 16'hFFFC, 0);
    cyc("rfix_inc", 0, 16'h0000, 0, 8'h00, 1, 16'hFFFD, 0);
    @(negedge clk);
    chk("sb.empty", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
